// File: rtl/ahb_wrr_arbiter_pkg.sv
// Shared types for the AHB weighted round-robin arbiter: burst encoding,
// arbiter states and the burst-length lookup.
package ahb_wrr_arbiter_pkg;

  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0,
    HB_INCR   = 3'd1,
    HB_WRAP4  = 3'd2,
    HB_INCR4  = 3'd3,
    HB_WRAP8  = 3'd4,
    HB_INCR8  = 3'd5,
    HB_WRAP16 = 3'd6,
    HB_INCR16 = 3'd7
  } hburst_type;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_t;

  localparam int BEAT_CNT_W = 5;

  // Undefined-length INCR returns 0; its end is decided by the owner's hreq.
  function automatic logic [BEAT_CNT_W-1:0] beat_limit(input hburst_type burst);
    case (burst)
      HB_SINGLE:            return 5'd1;
      HB_WRAP4,  HB_INCR4:  return 5'd4;
      HB_WRAP8,  HB_INCR8:  return 5'd8;
      HB_WRAP16, HB_INCR16: return 5'd16;
      default:              return 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_wrr_arbiter_beat_counter.sv
// Beat counter for the current burst: captures the beat limit on the first
// owned cycle and flags the cycle in which the final beat is accepted.
module ahb_burst_beat_counter
  import ahb_wrr_arbiter_pkg::*;
(
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       hsel,
  input  logic       hwait,
  input  logic       owner_req,
  input  hburst_type hburst,
  output logic       hlast
);

  logic [BEAT_CNT_W-1:0] count;
  logic [BEAT_CNT_W-1:0] limit_q;
  logic [BEAT_CNT_W-1:0] limit;
  logic                  undef_q;
  logic                  undef;
  logic                  captured;
  logic                  accept;

  assign accept = hsel & ~hwait;

  // Until captured, the live hburst is used so a SINGLE can end in its first cycle.
  always_comb begin
    limit = limit_q;
    undef = undef_q;
    if (!captured) begin
      limit = beat_limit(hburst);
      undef = (hburst == HB_INCR);
    end
  end

  assign hlast = accept & (undef ? ~owner_req : (count == (limit - 5'd1)));

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      count    <= '0;
      limit_q  <= '0;
      undef_q  <= 1'b0;
      captured <= 1'b0;
    end else if (!hsel || hlast) begin
      count    <= '0;
      captured <= 1'b0;
    end else begin
      if (!captured) begin
        captured <= 1'b1;
        limit_q  <= beat_limit(hburst);
        undef_q  <= (hburst == HB_INCR);
      end
      if (accept) begin
        count <= count + 5'd1;
      end
    end
  end

endmodule

// File: rtl/ahb_wrr_arbiter.sv
// Weighted round-robin AHB arbiter: each master gets hweight+1 bursts per turn.
// Optional starvation timer enabled by defining WRR_STARVE_TIMER_EN.
module ahb_wrr_arbiter
  import ahb_wrr_arbiter_pkg::*;
#(
  parameter int MASTER_NUM   = 4,
  parameter int WEIGHT_BIT   = 3,
  parameter int STARVE_LIMIT = 32
) (
  input  logic                                 hclk,
  input  logic                                 hreset_n,
  input  logic [MASTER_NUM-1:0]                hreq,
  input  hburst_type                           hburst,
  input  logic                                 hwait,
  input  logic [MASTER_NUM-1:0][WEIGHT_BIT-1:0] hweight,
  output logic [MASTER_NUM-1:0]                hgrant,
  output logic                                 hsel,
  output logic [$clog2(MASTER_NUM)-1:0]        hmaster,
  output logic                                 hlast
);

  localparam int PTR_W  = $clog2(MASTER_NUM);
  localparam int CRED_W = WEIGHT_BIT + 1;

  arb_state_t              state;
  logic [MASTER_NUM-1:0]   grant;
  logic [PTR_W-1:0]        owner;
  logic [PTR_W-1:0]        rr_ptr;
  logic [CRED_W-1:0]       credit;
  logic [PTR_W-1:0]        owner_next_ptr;
  logic [PTR_W-1:0]        scan_base;
  logic [PTR_W-1:0]        scan_idx;
  logic [PTR_W-1:0]        winner;
  logic                    winner_found;
  logic [MASTER_NUM-1:0]   winner_onehot;
  logic [CRED_W-1:0]       winner_credit;
  logic                    owner_req;
  logic                    keep_owner;
  logic                    starve_hit;

  assign hgrant  = grant & ~{MASTER_NUM{hwait}};
  assign hsel    = (state == BURST);
  assign hmaster = owner;

  assign owner_req      = hreq[owner];
  assign owner_next_ptr = (owner == PTR_W'(MASTER_NUM - 1)) ? '0 : owner + 1'b1;
  assign scan_base      = (state == IDLE) ? rr_ptr : owner_next_ptr;

  // First requester at or after scan_base, wrapping past the top index.
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    scan_idx     = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      scan_idx = PTR_W'((int'(scan_base) + i) % MASTER_NUM);
      if (!winner_found && hreq[scan_idx]) begin
        winner       = scan_idx;
        winner_found = 1'b1;
      end
    end
  end

  assign winner_onehot = MASTER_NUM'(1) << winner;
  assign winner_credit = {1'b0, hweight[winner]} + CRED_W'(1);
  assign keep_owner    = owner_req & (credit > CRED_W'(1)) & ~starve_hit;

`ifdef WRR_STARVE_TIMER_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt;
  logic                handover;

  assign handover   = hlast & ~keep_owner;
  assign starve_hit = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

  // Saturating count of cycles in which some other master is kept waiting.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      starve_cnt <= '0;
    end else if (state == IDLE || handover) begin
      starve_cnt <= '0;
    end else if (|(hreq & ~grant) && !starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Ownership only moves on an accepted final beat, so hwait freezes everything.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      credit <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (winner_found) begin
            state  <= BURST;
            grant  <= winner_onehot;
            owner  <= winner;
            credit <= winner_credit;
          end
        end
        BURST: begin
          if (hlast) begin
            if (keep_owner) begin
              credit <= credit - 1'b1;
            end else begin
              rr_ptr <= owner_next_ptr;
              if (winner_found) begin
                grant  <= winner_onehot;
                owner  <= winner;
                credit <= winner_credit;
              end else begin
                state  <= IDLE;
                grant  <= '0;
                credit <= '0;
              end
            end
          end else if (starve_hit) begin
            credit <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ahb_burst_beat_counter u_beat_counter (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .hsel      (hsel),
    .hwait     (hwait),
    .owner_req (owner_req),
    .hburst    (hburst),
    .hlast     (hlast)
  );

endmodule

// File: doc/ahb_wrr_arbiter.md
AHB_WRR_ARBITER -- requirements
Module: ahb_wrr_arbiter

Interface
REQ-001 Parameter MASTER_NUM, default 4, number of requesting masters sharing one slave (2..8).
REQ-002 Parameter WEIGHT_BIT, default 3, width of each per-master weight field.
REQ-003 Parameter STARVE_LIMIT, default 32, wait cycles before starvation handover (used only under REQ-029).
REQ-004 hclk  in  1  single clock, all state on rising edge.
REQ-005 hreset_n  in  1  asynchronous active-low reset.
REQ-006 hreq  in  MASTER_NUM  per-master bus request.
REQ-007 hburst  in  hburst_type  burst type of the current owner, valid while hsel=1.
REQ-008 hwait  in  1  slave not ready; beat not accepted while high.
REQ-009 hweight  in  MASTER_NUM x WEIGHT_BIT  static per-master weight; master gets hweight+1 bursts per turn.
REQ-010 hgrant  out  MASTER_NUM  registered one-hot grant, masked by hwait.
REQ-011 hsel  out  1  high when any master owns the slave.
REQ-012 hmaster  out  $clog2(MASTER_NUM)  binary index of the current owner.
REQ-013 hlast  out  1  high in the cycle the final beat of the current burst is accepted.

Function
REQ-014 FSM states SHALL be IDLE, BURST; IDLE->BURST when any hreq=1, BURST->IDLE on last beat accepted with no hreq pending.
REQ-015 Grant latency SHALL be one cycle: winner computed combinationally, registered into grant, hgrant = grant & ~hwait.
REQ-016 Winner SHALL be the first requester at or after rr_ptr in ascending index order with wrap-around from MASTER_NUM-1 to 0.
REQ-017 Beat limit SHALL be sampled at burst start: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16.
REQ-018 Beat counter (5 bits) SHALL increment only on hsel & ~hwait; hlast = hsel & ~hwait & (count == limit-1).
REQ-019 INCR (undefined length) SHALL end on the first accepted beat with owner hreq=0; hlast asserts on that beat.
REQ-020 Grant SHALL never change mid-burst; owner dropping hreq mid defined-length burst is ignored until hlast.
REQ-021 On hlast: credit decrements; if owner still requests and credit>0, owner is re-granted; else rr_ptr = owner+1 (mod MASTER_NUM) and arbitration reruns that cycle.
REQ-022 Credit SHALL reload to hweight[new owner]+1 whenever ownership moves to a different master.
REQ-023 Handover on hlast with another request pending SHALL have zero idle cycles (new grant in the next cycle).
REQ-024 hweight=0 SHALL give exactly one burst per turn; maximum weight gives 2^WEIGHT_BIT bursts.
REQ-025 hwait held high SHALL freeze count, credit, FSM and grant indefinitely.

Reset
REQ-026 On hreset_n=0: grant=0, hgrant=0, hsel=0, hmaster=0, hlast=0, count=0, credit=0, rr_ptr=0, state IDLE, immediately and asynchronously.
REQ-027 Reset asserted mid-burst SHALL abort the burst; first grant after release follows REQ-016 from rr_ptr=0.

Configuration
REQ-028 Macro WRR_STARVE_TIMER_EN SHALL gate the starvation timer.
REQ-029 With it defined: per-arbiter counter counts cycles where a non-owner requests and is not granted; at STARVE_LIMIT the owner's credit forces to 0 so handover occurs at the next hlast (never mid-burst); counter clears on any handover.
REQ-030 Without it: no timer logic, STARVE_LIMIT unused, behaviour purely REQ-021.

Structure
REQ-031 hburst_type and a beat-limit lookup function SHALL live in AHB_package; no new enum elsewhere.
REQ-032 One sub-module ahb_burst_beat_counter SHALL hold count, limit capture and hlast generation.

Verification
REQ-033 hreq=0001, hburst=INCR4, hwait=0 -> hgrant=0001 one cycle later, hlast on 4th beat, hsel=0 next cycle.
REQ-034 hreq=1111, all hweight=0, SINGLE -> grants 0001,0010,0100,1000,0001 on consecutive cycles.
REQ-035 hreq=0011, hweight[0]=2, hweight[1]=0, INCR4 -> master0 three bursts (12 beats), then master1 one burst.
REQ-036 INCR8 with hwait high on beats 3-5 -> count frozen, hlast only on 8th accepted beat, grant unchanged throughout.
REQ-037 WRR_STARVE_TIMER_EN, STARVE_LIMIT=8, hweight[0]=7, hreq=0011, INCR16 -> master1 granted at first hlast after 8 wait cycles.
REQ-038 hreset_n low during beat 2 of INCR8 -> all outputs 0 same cycle; after release hreq=0100 -> hgrant=0100 next cycle.
